// File: rtl/down_cnt_timer.sv
// down_cnt_timer: programmable down-counting timer with a one-cycle
// terminal-count pulse, optional auto-reload and a registered window flag
// that is set at HI_MARK and cleared at LO_MARK.
module down_cnt_timer #(
  parameter int WIDTH       = 3,
  parameter int RELOAD      = 5,
  parameter int AUTO_RELOAD = 1,
  parameter int HI_MARK     = 4,
  parameter int LO_MARK     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLEAR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             DOWN_ENABLE,
  input  logic             DOWN_ENABLE2,
  input  logic             STOP,
  output logic [WIDTH-1:0] DOWN_CNT,
  output logic             IS_ZERO,
  output logic             TC,
  output logic             WINDOW,
  output logic [1:0]       STATE
);

  localparam logic [WIDTH-1:0] RELOAD_V = WIDTH'(RELOAD);
  localparam logic [WIDTH-1:0] HI_V     = WIDTH'(HI_MARK);
  localparam logic [WIDTH-1:0] LO_V     = WIDTH'(LO_MARK);
  localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             win_q, win_d;
  logic             dec_req;

  assign dec_req  = DOWN_ENABLE | DOWN_ENABLE2;

  assign DOWN_CNT = cnt_q;
  assign IS_ZERO  = (cnt_q == '0);
  assign TC       = tc_q;
  assign WINDOW   = win_q;
  assign STATE    = state_q;

  // Register bank: reset leaves the timer idle, preloaded with RELOAD.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= RELOAD_V;
      state_q <= IDLE;
      tc_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tc_q    <= tc_d;
      win_q   <= win_d;
    end
  end

  // Next-state logic: CLEAR > LOAD > STOP > decrement/reload > hold; the
  // window flag looks at the current registered count so it lags by a cycle.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    tc_d    = 1'b0;
    win_d   = win_q;

    if (CLEAR) begin
      cnt_d   = '0;
      state_d = IDLE;
      win_d   = 1'b0;
    end else begin
      if (cnt_q == HI_V) begin
        win_d = 1'b1;
      end else if (cnt_q == LO_V) begin
        win_d = 1'b0;
      end

      if (LOAD) begin
        cnt_d = LOAD_VAL;
        if (LOAD_VAL == '0) begin
          state_d = EXPIRED;
          tc_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          RUN: begin
            if (STOP) begin
              state_d = PAUSE;
            end else if (dec_req && (cnt_q != '0)) begin
              cnt_d = cnt_q - ONE_V;
              if (cnt_q == ONE_V) begin
                tc_d    = 1'b1;
                state_d = EXPIRED;
              end
            end
          end
          PAUSE: begin
            if (!STOP) begin
              state_d = RUN;
            end
          end
          EXPIRED: begin
            if ((AUTO_RELOAD != 0) && dec_req) begin
              cnt_d   = RELOAD_V;
              state_d = RUN;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_cnt_timer.sv
// tb_down_cnt_timer: directed scenarios plus a randomized run, all checked
// against a behavioural model of the timer kept in this bench.
module tb_down_cnt_timer;

  localparam int WIDTH       = 3;
  localparam int RELOAD      = 5;
  localparam int AUTO_RELOAD = 1;
  localparam int HI_MARK     = 4;
  localparam int LO_MARK     = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CLEAR, LOAD, DOWN_ENABLE, DOWN_ENABLE2, STOP;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] DOWN_CNT;
  logic             IS_ZERO, TC, WINDOW;
  logic [1:0]       STATE;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: count as a plain integer, mode 0..3 as in STATE.
  int m_cnt;
  int m_state;
  bit m_tc;
  bit m_win;

  down_cnt_timer #(
    .WIDTH(WIDTH), .RELOAD(RELOAD), .AUTO_RELOAD(AUTO_RELOAD),
    .HI_MARK(HI_MARK), .LO_MARK(LO_MARK)
  ) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .DOWN_ENABLE(DOWN_ENABLE), .DOWN_ENABLE2(DOWN_ENABLE2), .STOP(STOP),
    .DOWN_CNT(DOWN_CNT), .IS_ZERO(IS_ZERO), .TC(TC), .WINDOW(WINDOW),
    .STATE(STATE)
  );

  // 10-unit clock.
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_cnt   = RELOAD;
    m_state = 0;
    m_tc    = 1'b0;
    m_win   = 1'b0;
  endtask

  task automatic model_edge();
    bit en;
    int old;
    en  = DOWN_ENABLE || DOWN_ENABLE2;
    old = m_cnt;
    if (CLEAR) begin
      m_cnt = 0; m_state = 0; m_tc = 1'b0; m_win = 1'b0;
      return;
    end
    m_tc = 1'b0;
    if (old == HI_MARK) m_win = 1'b1;
    else if (old == LO_MARK) m_win = 1'b0;
    if (LOAD) begin
      m_cnt   = int'(LOAD_VAL);
      m_state = (m_cnt == 0) ? 3 : 1;
      m_tc    = (m_cnt == 0);
    end else begin
      case (m_state)
        1: begin
          if (STOP) m_state = 2;
          else if (en && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_tc = 1'b1; m_state = 3;
            end
          end
        end
        2: if (!STOP) m_state = 1;
        3: if (AUTO_RELOAD == 1 && en) begin
             m_cnt = RELOAD; m_state = 1;
           end
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] exp_pack(int c, int s, bit t, bit w);
    return {3'(c), 2'(s), t, w, (c == 0)};
  endfunction

  function automatic logic [7:0] model_pack();
    return {3'(m_cnt), 2'(m_state), m_tc, m_win, (m_cnt == 0)};
  endfunction

  function automatic logic [7:0] dut_pack();
    return {DOWN_CNT, STATE, TC, WINDOW, IS_ZERO};
  endfunction

  task automatic set_in(bit clr, bit ld, int lv, bit de, bit de2, bit stp);
    CLEAR        = clr;
    LOAD         = ld;
    LOAD_VAL     = 3'(lv);
    DOWN_ENABLE  = de;
    DOWN_ENABLE2 = de2;
    STOP         = stp;
  endtask

  // One clock: model follows the edge, outputs are sampled at the negedge.
  task automatic apply_cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++;
    if (dut_pack() !== exp_pack(5, 0, 0, 0)) begin
      n_fail++;
      $display("[TB] FAIL reset: got %b expected %b (cnt,st,tc,win,zero)", dut_pack(), exp_pack(5, 0, 0, 0));
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_count();
    logic [7:0] exp[5];
    exp = '{exp_pack(3,1,0,0), exp_pack(2,1,0,0), exp_pack(1,1,0,0),
            exp_pack(0,3,1,0), exp_pack(0,3,0,0)};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(0, 1, 3, 0, 0, 0);
      else if (i < 4) set_in(0, 0, 0, 1, 0, 0);
      else set_in(0, 0, 0, 0, 0, 0);
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL count step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp[7];
    exp = '{exp_pack(5,1,0,0), exp_pack(4,1,0,0), exp_pack(3,1,0,1),
            exp_pack(2,1,0,1), exp_pack(1,1,0,0), exp_pack(0,3,1,0),
            exp_pack(0,3,0,0)};
    for (int i = 0; i < 7; i++) begin
      if (i == 0) set_in(0, 0, 0, 0, 1, 0);
      else if (i < 6) set_in(0, 0, 0, 1, 0, 0);
      else set_in(0, 0, 0, 0, 0, 0);
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL reload step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp[4];
    exp = '{exp_pack(5,1,0,0), exp_pack(4,1,0,0), exp_pack(6,1,0,1),
            exp_pack(0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_in(0, 1, 5, 0, 0, 0);
        1: set_in(0, 0, 0, 1, 1, 0);
        2: set_in(0, 1, 6, 1, 0, 0);
        default: set_in(1, 1, 6, 0, 0, 0);
      endcase
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL simultaneous step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] exp[7];
    exp = '{exp_pack(0,0,0,0), exp_pack(4,1,0,0), exp_pack(4,2,0,1),
            exp_pack(4,2,0,1), exp_pack(4,2,0,1), exp_pack(4,1,0,1),
            exp_pack(3,1,0,1)};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: set_in(0, 0, 0, 1, 0, 0);
        1: set_in(0, 1, 4, 0, 0, 0);
        2, 3, 4: set_in(0, 0, 0, 1, 0, 1);
        default: set_in(0, 0, 0, 1, 0, 0);
      endcase
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL pause step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
  endtask

  task automatic test_window();
    logic [7:0] exp[7];
    exp = '{exp_pack(0,0,0,0), exp_pack(6,1,0,0), exp_pack(5,1,0,0),
            exp_pack(4,1,0,0), exp_pack(3,1,0,1), exp_pack(2,1,0,1),
            exp_pack(1,1,0,0)};
    for (int i = 0; i < 7; i++) begin
      if (i == 0) set_in(1, 0, 0, 0, 0, 0);
      else if (i == 1) set_in(0, 1, 6, 0, 0, 0);
      else set_in(0, 0, 0, 1, 0, 0);
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL window step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
  endtask

  task automatic test_load_zero();
    logic [7:0] exp[2];
    exp = '{exp_pack(0,3,1,0), exp_pack(0,3,0,0)};
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_in(0, 1, 0, 0, 0, 0);
      else set_in(0, 0, 0, 0, 0, 0);
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL load_zero step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[3];
    exp = '{exp_pack(4,1,0,0), exp_pack(3,1,0,1), exp_pack(2,1,0,1)};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_in(0, 1, 4, 0, 0, 0);
      else set_in(0, 0, 0, 1, 0, 0);
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL reset_mid step %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), exp[i]);
      end
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if (dut_pack() !== exp_pack(5, 0, 0, 0)) begin
      n_fail++;
      $display("[TB] FAIL reset_mid async: got %b expected %b (cnt,st,tc,win,zero)", dut_pack(), exp_pack(5, 0, 0, 0));
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    set_in(0, 0, 0, 1, 1, 0);
    apply_cycle();
    n_cmp++;
    if (dut_pack() !== exp_pack(5, 0, 0, 0)) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %b expected %b (cnt,st,tc,win,zero)", dut_pack(), exp_pack(5, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 20) == 0, ($urandom % 8) == 0, int'($urandom % 8),
             ($urandom % 2) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0);
      apply_cycle();
      n_cmp++;
      if (dut_pack() !== model_pack()) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b (cnt,st,tc,win,zero)", i, dut_pack(), model_pack());
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_count();
    test_auto_reload();
    test_simultaneous();
    test_pause();
    test_window();
    test_load_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/down_cnt_timer.md
# down_cnt_timer

Programmable down-counting timer: the decrementing counterpart to the block's enable-driven up counters. It loads a start value, decrements on either of two enables, and flags expiry with a one-cycle terminal-count pulse. It optionally auto-reloads, and drives a registered window flag between two count marks. It sits beside the up-counter logic in TOP and provides countdown and timeout qualification to downstream control.

## Interface
- WIDTH, 3: counter width in bits.
- RELOAD, 5: value loaded at reset and on auto-reload; must be ≤ 2^WIDTH-1.
- AUTO_RELOAD, 1: 1 = restart from RELOAD after expiry; 0 = stop in EXPIRED.
- HI_MARK, 4: count value that sets WINDOW.
- LO_MARK, 2: count value that clears WINDOW; requires HI_MARK > LO_MARK.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous and active-high.
- CLEAR  in  1  synchronous clear to zero or IDLE; highest priority.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  WIDTH  start value.
- DOWN_ENABLE  in  1  decrement request.
- DOWN_ENABLE2  in  1  second decrement request; ORed with DOWN_ENABLE.
- STOP  in  1  pause request.
- DOWN_CNT  out  WIDTH  registered count.
- IS_ZERO  out  1  combinational, DOWN_CNT == 0.
- TC  out  1  registered terminal-count pulse.
- WINDOW  out  1  registered window flag.
- STATE  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.

## Operation
- **Reset values:** DOWN_CNT=RELOAD, STATE=IDLE, TC=0, WINDOW=0.
- **Per-cycle priority:** CLEAR > LOAD > STOP > decrement > hold.
- **CLEAR:** DOWN_CNT←0, STATE←IDLE, WINDOW←0, TC←0. Valid from any state.
- **LOAD:** DOWN_CNT←LOAD_VAL, from any state.
  - LOAD_VAL≠0: STATE←RUN.
  - LOAD_VAL=0: STATE←EXPIRED and TC←1 on the same edge.
- **IDLE:** holds the count. Enables are ignored. Exit only via LOAD.
- **RUN:**
  - STOP=1: STATE←PAUSE; no decrement that cycle.
  - Else, if DOWN_ENABLE|DOWN_ENABLE2: DOWN_CNT←DOWN_CNT-1. Both enables high still decrement by exactly 1.
  - Decrement from 1: DOWN_CNT←0, TC←1, STATE←EXPIRED.
- **PAUSE:** count frozen and enables ignored. STOP=0 returns to RUN the next edge; decrement resumes the cycle after that.
- **EXPIRED:** DOWN_CNT=0.
  - AUTO_RELOAD=1 and any enable high: DOWN_CNT←RELOAD, STATE←RUN. This is the wrap 0→RELOAD and is not a decrement.
  - AUTO_RELOAD=0: holds until LOAD or CLEAR.
- **Arithmetic:** the count never decrements below 0. No path produces the value 2^WIDTH-1 through underflow.
- **TC:** high for exactly one cycle per expiry. Default 0 every cycle unless set by the rules above.
- **WINDOW:** evaluated on the current registered DOWN_CNT, unless CLEAR is asserted.
  - DOWN_CNT==HI_MARK → WINDOW←1.
  - DOWN_CNT==LO_MARK → WINDOW←0.
  - Otherwise hold.
  - A LOAD does not directly change WINDOW.

## Timing
- DOWN_CNT, TC, STATE and WINDOW are all registered. IS_ZERO is the only combinational output.
- Decrement latency: an enable sampled at edge N updates DOWN_CNT after edge N.
- TC asserts in the same cycle DOWN_CNT first reads 0, whether from a decrement or from a LOAD of 0.
- WINDOW lags DOWN_CNT by one cycle. Example: DOWN_CNT reads 4 in cycle k, so WINDOW=1 from cycle k+1.
- RST assertion mid-count forces reset values asynchronously. Counting needs a LOAD after release, since reset leaves STATE=IDLE.
- LOAD together with an enable: the load wins and the enable is discarded.
- CLEAR together with LOAD: the clear wins.
- STOP together with LOAD: LOAD wins and STATE←RUN.

## Test plan
- **Reset then count:** RST pulse → DOWN_CNT=5, STATE=0. LOAD_VAL=3 with LOAD, then DOWN_ENABLE held → counts 3,2,1,0. TC=1 only in the cycle DOWN_CNT=0, then STATE=3.
- **Auto-reload wrap:** AUTO_RELOAD=1. In EXPIRED, DOWN_ENABLE2=1 → DOWN_CNT=5, STATE=1, no TC. Repeat expiry gives a second single-cycle TC.
- **Simultaneous events:**
  - Both enables high from 5 → 4, not 3.
  - LOAD=1 and DOWN_ENABLE=1 with LOAD_VAL=6 → 6.
  - CLEAR=1 and LOAD=1 → DOWN_CNT=0, STATE=0.
- **Pause:** in RUN at 4, STOP=1 for 3 cycles with DOWN_ENABLE=1 → DOWN_CNT stays 4 and STATE=2. Release STOP → 4 (STATE=1), then 3.
- **Window:** LOAD 6, decrement each cycle → WINDOW rises the cycle after DOWN_CNT=4 and falls the cycle after DOWN_CNT=2.
- **Edge cases:**
  - LOAD_VAL=0 → STATE=3, TC=1 for one cycle, IS_ZERO=1.
  - RST asserted at DOWN_CNT=2 → immediate DOWN_CNT=5, WINDOW=0, TC=0.
